// File: rtl/chip8_timers_pkg.sv
// Shared definitions for the CHIP-8 delay/sound timer block.
package chip8_timers_pkg;

  localparam logic TIMER_SEL_DELAY = 1'b0;
  localparam logic TIMER_SEL_SOUND = 1'b1;
  localparam int   TIMER_W         = 8;

  typedef enum logic {
    TONE_IDLE = 1'b0,
    TONE_RUN  = 1'b1
  } tone_state_e;

endpackage

// File: rtl/chip8_timers_tone_gen.sv
// Square-wave tone generator: toggles every HALF cycles while enabled,
// always restarting low with the phase at zero.
module tone_gen
  import chip8_timers_pkg::*;
#(
  parameter int HALF = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tone
);

  localparam int unsigned PW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(HALF - 1);

  tone_state_e   state_q, state_d;
  logic [PW-1:0] phase_cnt, phase_d;
  logic          beep_q, beep_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= TONE_IDLE;
      phase_cnt <= '0;
      beep_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_cnt <= phase_d;
      beep_q    <= beep_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_cnt;
    beep_d  = beep_q;
    unique case (state_q)
      TONE_IDLE: begin
        phase_d = '0;
        beep_d  = 1'b0;
        if (en) state_d = TONE_RUN;
      end
      TONE_RUN: begin
        if (!en) begin
          state_d = TONE_IDLE;
          phase_d = '0;
          beep_d  = 1'b0;
        end else if (phase_cnt == PHASE_LAST) begin
          phase_d = '0;
          beep_d  = ~beep_q;
        end else begin
          phase_d = phase_cnt + PW'(1);
        end
      end
      default: state_d = TONE_IDLE;
    endcase
  end

  assign tone = beep_q;

endmodule

// File: rtl/chip8_timers.sv
// CHIP-8 delay and sound timers: CPU-loadable, 60 Hz countdown with
// saturation at zero, and a tone output while the sound timer runs.
module chip8_timers
  import chip8_timers_pkg::*;
#(
  parameter int CLK_HZ  = 12000000,
  parameter int TONE_HZ = 440
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               timer_60hz_tick,
  input  logic               wr_en,
  input  logic               wr_sel,
  input  logic [TIMER_W-1:0] wr_data,
  output logic [TIMER_W-1:0] dt_value,
  output logic               st_active,
  output logic               beep
);

  localparam int HALF = CLK_HZ / (2 * TONE_HZ);

  logic [TIMER_W-1:0] dt, st;
  logic               wr_dt, wr_st;

  assign wr_dt = wr_en && (wr_sel == TIMER_SEL_DELAY);
  assign wr_st = wr_en && (wr_sel == TIMER_SEL_SOUND);

  // A write beats a same-cycle tick for the selected register only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dt <= '0;
      st <= '0;
    end else begin
      if (wr_dt)
        dt <= wr_data;
      else if (timer_60hz_tick && dt != '0)
        dt <= dt - TIMER_W'(1);

      if (wr_st)
        st <= wr_data;
      else if (timer_60hz_tick && st != '0)
        st <= st - TIMER_W'(1);
    end
  end

  assign dt_value  = dt;
  assign st_active = (st != '0);

  tone_gen #(
    .HALF (HALF)
  ) u_tone_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (st_active),
    .tone (beep)
  );

endmodule

// File: tb/tb_chip8_timers.sv
// Directed self-checking bench for chip8_timers with HALF = 5.
module tb_chip8_timers;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       timer_60hz_tick = 1'b0;
  logic       wr_en = 1'b0;
  logic       wr_sel = 1'b0;
  logic [7:0] wr_data = 8'd0;
  logic [7:0] dt_value;
  logic       st_active;
  logic       beep;

  int vectors = 0;
  int miscompares = 0;

  chip8_timers #(
    .CLK_HZ  (1000),
    .TONE_HZ (100)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .timer_60hz_tick (timer_60hz_tick),
    .wr_en           (wr_en),
    .wr_sel          (wr_sel),
    .wr_data         (wr_data),
    .dt_value        (dt_value),
    .st_active       (st_active),
    .beep            (beep)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (dt_value !== 8'd0 || st_active !== 1'b0 || beep !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_held: dt=%0d st_active=%b beep=%b, required 0/0/0", dt_value, st_active, beep);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      vectors++;
      if (dt_value !== 8'd0 || st_active !== 1'b0 || beep !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_idle cycle %0d: dt=%0d st_active=%b beep=%b, required 0/0/0", i, dt_value, st_active, beep);
      end
    end
  endtask

  task automatic test_dt_countdown();
    logic [7:0] exp_seq [4] = '{8'd2, 8'd1, 8'd0, 8'd0};
    wr_en = 1'b1; wr_sel = 1'b0; wr_data = 8'd3;
    step();
    wr_en = 1'b0;
    vectors++;
    if (dt_value !== 8'd3) begin
      miscompares++;
      $display("FAIL dt_load: got %0d, required 3", dt_value);
    end
    for (int i = 0; i < 4; i++) begin
      repeat (9) step();
      timer_60hz_tick = 1'b1;
      step();
      timer_60hz_tick = 1'b0;
      vectors++;
      if (dt_value !== exp_seq[i]) begin
        miscompares++;
        $display("FAIL dt_tick %0d: got %0d, required %0d", i, dt_value, exp_seq[i]);
      end
    end
  endtask

  task automatic test_write_tick();
    wr_en = 1'b1; wr_sel = 1'b0; wr_data = 8'd5; timer_60hz_tick = 1'b1;
    step();
    wr_en = 1'b0; timer_60hz_tick = 1'b0;
    vectors++;
    if (dt_value !== 8'd5) begin
      miscompares++;
      $display("FAIL write_wins: got %0d, required 5", dt_value);
    end
    repeat (3) step();
    timer_60hz_tick = 1'b1;
    step();
    timer_60hz_tick = 1'b0;
    vectors++;
    if (dt_value !== 8'd4) begin
      miscompares++;
      $display("FAIL tick_after_write: got %0d, required 4", dt_value);
    end
  endtask

  task automatic test_sound();
    logic exp_beep;
    wr_en = 1'b1; wr_sel = 1'b1; wr_data = 8'd2;
    step();
    wr_en = 1'b0;
    vectors++;
    if (st_active !== 1'b1 || beep !== 1'b0) begin
      miscompares++;
      $display("FAIL st_load: st_active=%b beep=%b, required 1/0", st_active, beep);
    end
    // Edge 1 enters RUN; beep then toggles on every 5th edge.
    for (int k = 1; k <= 20; k++) begin
      step();
      exp_beep = (((k - 1) / 5) % 2) == 1;
      vectors++;
      if (beep !== exp_beep) begin
        miscompares++;
        $display("FAIL beep_wave k=%0d: got %b, required %b", k, beep, exp_beep);
      end
    end
    timer_60hz_tick = 1'b1;
    step();
    vectors++;
    if (st_active !== 1'b1 || dt_value !== 8'd3) begin
      miscompares++;
      $display("FAIL st_tick1: st_active=%b dt=%0d, required 1/3", st_active, dt_value);
    end
    step();
    timer_60hz_tick = 1'b0;
    vectors++;
    if (st_active !== 1'b0 || dt_value !== 8'd2) begin
      miscompares++;
      $display("FAIL st_tick2: st_active=%b dt=%0d, required 0/2", st_active, dt_value);
    end
    step();
    vectors++;
    if (beep !== 1'b0) begin
      miscompares++;
      $display("FAIL beep_stop: got %b, required 0", beep);
    end
  endtask

  task automatic test_st_clear();
    wr_en = 1'b1; wr_sel = 1'b0; wr_data = 8'd7;
    step();
    wr_sel = 1'b1; wr_data = 8'd10;
    step();
    wr_en = 1'b0;
    repeat (7) step();
    vectors++;
    if (beep !== 1'b1 || st_active !== 1'b1) begin
      miscompares++;
      $display("FAIL st10_running: beep=%b st_active=%b, required 1/1", beep, st_active);
    end
    wr_en = 1'b1; wr_sel = 1'b1; wr_data = 8'd0; timer_60hz_tick = 1'b1;
    step();
    wr_en = 1'b0; timer_60hz_tick = 1'b0;
    vectors++;
    if (st_active !== 1'b0 || dt_value !== 8'd6) begin
      miscompares++;
      $display("FAIL st_clear: st_active=%b dt=%0d, required 0/6", st_active, dt_value);
    end
    step();
    vectors++;
    if (beep !== 1'b0) begin
      miscompares++;
      $display("FAIL st_clear_beep: got %b, required 0", beep);
    end
  endtask

  task automatic test_async_reset();
    wr_en = 1'b1; wr_sel = 1'b0; wr_data = 8'd9;
    step();
    wr_sel = 1'b1; wr_data = 8'd8;
    step();
    wr_en = 1'b0;
    repeat (7) step();
    vectors++;
    if (beep !== 1'b1 || st_active !== 1'b1 || dt_value !== 8'd9) begin
      miscompares++;
      $display("FAIL pre_reset: beep=%b st_active=%b dt=%0d, required 1/1/9", beep, st_active, dt_value);
    end
    rst = 1'b1;
    wr_en = 1'b1; wr_sel = 1'b1; wr_data = 8'd5;
    #2;
    vectors++;
    if (dt_value !== 8'd0 || st_active !== 1'b0 || beep !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: dt=%0d st_active=%b beep=%b, required 0/0/0", dt_value, st_active, beep);
    end
    step();
    step();
    rst = 1'b0;
    wr_en = 1'b0;
    step();
    vectors++;
    if (dt_value !== 8'd0 || st_active !== 1'b0 || beep !== 1'b0) begin
      miscompares++;
      $display("FAIL write_in_reset: dt=%0d st_active=%b beep=%b, required 0/0/0", dt_value, st_active, beep);
    end
  endtask

  initial begin
    test_reset();
    test_dt_countdown();
    test_write_tick();
    test_sound();
    test_st_clear();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
